// File: rtl/pc_stack.sv
// pc_stack: program counter for the multi-cycle core with absolute jumps,
// condition-selectable relative branches, a call/return stack, stall and
// sticky stack error flags. PC, depth and flags are registered, so no input
// reaches an output combinationally.
//
// Control protocol: every strobe (ret_en, call_en, jmp_en, br_en) is a
// single-cycle request sampled at the rising edge; there is no ready/ack,
// a request is always consumed on the edge it is seen unless stall is high,
// in which case it is dropped. Only the highest-priority strobe acts.
module pc_stack #(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned START_ADDR  = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   stall,
    input  logic                   br_en,
    input  logic                   br_ne,
    input  logic                   z,
    input  logic signed [PC_W-1:0] bamt,
    input  logic                   jmp_en,
    input  logic                   call_en,
    input  logic                   ret_en,
    input  logic        [PC_W-1:0] jaddr,
    output logic        [PC_W-1:0] PC,
    output logic                   stack_empty,
    output logic                   stack_full,
    output logic                   ovf_err,
    output logic                   unf_err
);

    // Depth counts 0..STACK_DEPTH inclusive; entry index only needs 0..STACK_DEPTH-1.
    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DW-1:0]   DEPTH_MAX = DW'(STACK_DEPTH);
    localparam logic [PC_W-1:0] PC_RESET  = PC_W'(START_ADDR);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [PC_W-1:0] stack_q [STACK_DEPTH];

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;
    logic [AW-1:0]   push_idx;
    logic [AW-1:0]   pop_idx;
    logic            push_en;
    logic            is_empty;
    logic            is_full;
    logic            br_taken;

    // Sums wrap silently modulo 2^PC_W; bamt is relative to the current PC.
    assign pc_inc   = pc_q + PC_W'(1);
    assign pc_br    = pc_q + bamt;
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DEPTH_MAX);
    assign br_taken = br_en && (z != br_ne);
    // Push only happens when not full and pop only when not empty, so the
    // truncated indices are always in range when they are used.
    assign push_idx = depth_q[AW-1:0];
    assign pop_idx  = AW'(depth_q - DW'(1));

    // Next-state selection by fixed priority: stall, ret, call, jmp, branch, increment.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (!stall) begin
            if (ret_en) begin
                if (!is_empty) begin
                    pc_d    = stack_q[pop_idx];
                    depth_d = depth_q - DW'(1);
                end else begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end
            end else if (call_en) begin
                pc_d = jaddr;
                if (!is_full) begin
                    push_en = 1'b1;
                    depth_d = depth_q + DW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (jmp_en) begin
                pc_d = jaddr;
            end else if (br_taken) begin
                pc_d = pc_br;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // PC, depth and sticky flags; reset takes effect immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= PC_RESET;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign PC          = pc_q;
    assign stack_empty = is_empty;
    assign stack_full  = is_full;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack (PC_W=8, STACK_DEPTH=4, START_ADDR=0): directed test-plan
// sequences followed by random strobes, checked against a queue-based model.
module tb_pc_stack;

  localparam int PC_W  = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            stall = 1'b0;
  logic            br_en = 1'b0;
  logic            br_ne = 1'b0;
  logic            z = 1'b0;
  logic [PC_W-1:0] bamt = '0;
  logic            jmp_en = 1'b0;
  logic            call_en = 1'b0;
  logic            ret_en = 1'b0;
  logic [PC_W-1:0] jaddr = '0;
  logic [PC_W-1:0] pc;
  logic            stack_empty, stack_full, ovf_err, unf_err;

  always #5 clk = ~clk;

  pc_stack #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .START_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .br_en(br_en), .br_ne(br_ne),
    .z(z), .bamt(bamt), .jmp_en(jmp_en), .call_en(call_en), .ret_en(ret_en),
    .jaddr(jaddr), .PC(pc), .stack_empty(stack_empty), .stack_full(stack_full),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  // ---------------- reference model ----------------
  logic [PC_W-1:0] m_pc;
  int              m_stack[$];
  bit              m_ovf, m_unf;

  localparam int OW = PC_W + 4;
  logic [OW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [OW-1:0] model_out();
    return {m_pc, m_stack.size() == 0, m_stack.size() == DEPTH, m_ovf, m_unf};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {pc, stack_empty, stack_full, ovf_err, unf_err};
  endfunction

  task automatic model_reset();
    m_pc = '0;
    m_stack.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%0d e/f/o/u=%b required pc=%0d e/f/o/u=%b at %0t",
               name, got[OW-1:4], got[3:0], exp[OW-1:4], exp[3:0], $time);
    end
  endtask

  task automatic check_pc(input string name, input logic [PC_W-1:0] exp);
    @(posedge clk);
    #1;
    n_tests++;
    if (pc !== exp) begin
      n_fail++;
      $display("FAIL %s: got PC=%0d required PC=%0d", name, pc, exp);
    end
  endtask

  task automatic check_flags(input string name, input logic [3:0] exp);
    n_tests++;
    if ({stack_empty, stack_full, ovf_err, unf_err} !== exp) begin
      n_fail++;
      $display("FAIL %s: got e/f/o/u=%b required %b", name,
               {stack_empty, stack_full, ovf_err, unf_err}, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of strobes at the falling edge and queues the model's
  // expected outputs for the following rising edge.
  task automatic step(input bit s, input bit br, input bit ne, input bit zz,
                      input logic [PC_W-1:0] amt, input bit j, input bit c,
                      input bit r, input logic [PC_W-1:0] ja);
    @(negedge clk);
    stall = s; br_en = br; br_ne = ne; z = zz; bamt = amt;
    jmp_en = j; call_en = c; ret_en = r; jaddr = ja;
    if (!s) begin
      if (r) begin
        if (m_stack.size() > 0) m_pc = PC_W'(m_stack.pop_back());
        else begin
          m_pc = m_pc + 1'b1;
          m_unf = 1;
        end
      end else if (c) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(int'(m_pc + 1'b1));
        else m_ovf = 1;
        m_pc = ja;
      end else if (j) begin
        m_pc = ja;
      end else if (br && (zz != ne)) begin
        m_pc = m_pc + amt;
      end else begin
        m_pc = m_pc + 1'b1;
      end
    end
    exp_q.push_back(model_out());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, 0, 0, 0, '0);
  endtask

  task automatic jump(input logic [PC_W-1:0] a);
    step(0, 0, 0, 0, '0, 1, 0, 0, a);
  endtask

  task automatic call(input logic [PC_W-1:0] a);
    step(0, 0, 0, 0, '0, 0, 1, 0, a);
  endtask

  task automatic ret();
    step(0, 0, 0, 0, '0, 0, 0, 1, '0);
  endtask

  // Reset asserted mid-cycle with a call pending: outputs must take reset
  // values at once and the call must be lost. Release just after an edge.
  task automatic mid_reset(input string name);
    @(negedge clk);
    call_en = 1'b1; jaddr = 8'h77; ret_en = 1'b0; jmp_en = 1'b0;
    stall = 1'b0; br_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check(name, dut_out(), {8'd0, 4'b1000});
    call_en = 1'b0; jaddr = '0;
    @(posedge clk);
    #2;
    check({name, "_held"}, dut_out(), {8'd0, 4'b1000});
    reset_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("cycle", dut_out(), exp_q.pop_front());
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #2;
    check("reset_state", dut_out(), {8'd0, 4'b1000});
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Reset and count.
    idle(); idle(); idle();
    check_pc("count_3", 8'd3);
    mid_reset("reset_mid_call");

    // Branch sense and wrap.
    jump(8'd10);
    step(0, 1, 0, 1, 8'hFC, 0, 0, 0, '0);
    check_pc("beq_taken_back", 8'd6);
    jump(8'd10);
    step(0, 1, 1, 1, 8'hFC, 0, 0, 0, '0);
    check_pc("bne_not_taken", 8'd11);
    jump(8'd250);
    step(0, 1, 0, 1, 8'd10, 0, 0, 0, '0);
    check_pc("branch_wrap", 8'd4);
    jump(8'd255);
    idle();
    check_pc("incr_wrap", 8'd0);

    // Call/return nesting.
    jump(8'd5);
    call(8'h40);
    idle(); idle();
    call(8'h80);
    check_pc("call_nested", 8'h80);
    ret();
    check_pc("ret_inner", 8'h43);
    ret();
    check_pc("ret_outer", 8'd6);
    check_flags("nest_flags", 4'b1000);

    // Overflow / underflow.
    for (int i = 0; i < 4; i++) call(8'h20);
    check_pc("call4_pc", 8'h20);
    check_flags("full_after_4", 4'b0100);
    call(8'h20);
    check_pc("call5_pc", 8'h20);
    check_flags("ovf_after_5", 4'b0110);
    for (int i = 0; i < 5; i++) ret();
    check_pc("ret5_pc", 8'd8);
    check_flags("unf_after_5", 4'b1011);
    idle(); idle();
    check_pc("flags_sticky_pc", 8'd10);
    check_flags("flags_sticky", 4'b1011);
    mid_reset("reset_clears_flags");

    // Priority and stall.
    call(8'h30);
    step(0, 0, 0, 0, '0, 1, 1, 1, 8'h99);
    check_pc("ret_call_jmp_pops", 8'd1);
    check_flags("priority_depth0", 4'b1000);
    step(0, 1, 0, 1, 8'd20, 1, 0, 0, 8'h55);
    check_pc("jmp_over_branch", 8'h55);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, 0, 1, 0, 8'h66);
    check_pc("stall_hold", 8'h55);
    check_flags("stall_flags", 4'b1000);

    // Random strobes against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        mid_reset("reset_random");
      end else begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             PC_W'($urandom_range(0, 255)), $urandom_range(0, 9) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
             PC_W'($urandom_range(0, 255)));
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
